// File: rtl/bricks_pkg.sv
// bricks_pkg: shared constants and types for the Bricks playfield.
//   Grid geometry (12 rows x 16 columns, paddle on row 11), ball direction
//   encodings, game_state encodings, internal FSM state type, and the
//   row/column to occupancy-vector index helper (index = row*16 + col).
package bricks_pkg;

    localparam int unsigned GRID_ROWS  = 12;
    localparam int unsigned GRID_COLS  = 16;
    localparam int unsigned GRID_CELLS = GRID_ROWS * GRID_COLS;
    localparam int unsigned PADDLE_ROW = 11;

    // Ball_direction: bit 1 selects row step (0: -1, 1: +1),
    // bit 0 selects column step (0: -1, 1: +1).
    typedef enum logic [1:0] {
        DIR_UP_RIGHT   = 2'b00,
        DIR_UP_LEFT    = 2'b01,
        DIR_DOWN_RIGHT = 2'b10,
        DIR_DOWN_LEFT  = 2'b11
    } dir_t;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_WIN  = 2'b10;
    localparam logic [1:0] GS_LOSE = 2'b11;

    // Low two bits equal the reported game_state; SERVE reports as PLAY.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_PLAY  = 3'b001,
        ST_WIN   = 3'b010,
        ST_LOSE  = 3'b011,
        ST_SERVE = 3'b101
    } state_t;

    // Row occupies the high nibble, column the low nibble.
    function automatic logic [7:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/brick_hit_detect.sv
// brick_hit_detect: combinational brick collision finder.
//   brick_map  in  192  current bricks (index = row*16+col)
//   row, col   in  4    ball position
//   dir        in  2    ball direction (see bricks_pkg::dir_t)
//   clear_mask out 192  bricks struck this step
//   hits       out 2    number of bricks struck (0..2)
// Candidates: V=(r+dr,c), H=(r,c+dc), D=(r+dr,c+dc); off-grid candidates are
// ignored and D only counts when neither V nor H holds a brick.
module brick_hit_detect
    import bricks_pkg::*;
(
    input  logic [GRID_CELLS-1:0] brick_map,
    input  logic [3:0]            row,
    input  logic [3:0]            col,
    input  logic [1:0]            dir,
    output logic [GRID_CELLS-1:0] clear_mask,
    output logic [1:0]            hits
);

    logic [4:0] next_row;
    logic [4:0] next_col;
    logic       row_in;
    logic       v_in;
    logic       h_in;
    logic       v_hit;
    logic       h_hit;
    logic       d_hit;
    logic [7:0] v_idx;
    logic [7:0] h_idx;
    logic [7:0] d_idx;

    always_comb begin
        clear_mask = '0;
        hits       = '0;

        // One extra bit so that stepping off row/col 0 lands at 31 (off-grid)
        // instead of wrapping to the far edge.
        next_row = {1'b0, row} + (dir[1] ? 5'd1 : 5'd31);
        next_col = {1'b0, col} + (dir[0] ? 5'd1 : 5'd31);

        row_in = ({1'b0, row} < 5'(GRID_ROWS));
        v_in   = (next_row < 5'(GRID_ROWS));
        h_in   = row_in && (next_col < 5'(GRID_COLS));

        v_idx = cell_index(next_row[3:0], col);
        h_idx = cell_index(row, next_col[3:0]);
        d_idx = cell_index(next_row[3:0], next_col[3:0]);

        v_hit = v_in && brick_map[v_idx];
        h_hit = h_in && brick_map[h_idx];
        d_hit = v_in && (next_col < 5'(GRID_COLS)) && !v_hit && !h_hit && brick_map[d_idx];

        if (v_hit) clear_mask[v_idx] = 1'b1;
        if (h_hit) clear_mask[h_idx] = 1'b1;
        if (d_hit) clear_mask[d_idx] = 1'b1;

        hits = {1'b0, v_hit} + {1'b0, h_hit} + {1'b0, d_hit};
    end

endmodule

// File: rtl/playfield_manager.sv
// playfield_manager: Bricks game grid owner.
//   Keeps the brick map and paddle, composes the 192-bit occupancy vector for
//   ball_movement, clears struck bricks, keeps score and runs the game FSM.
// Ports:
//   clock          in   1    game step clock (one edge = one ball step)
//   reset          in   1    asynchronous, active-low
//   start          in   1    starts a game from IDLE, returns to IDLE from WIN/LOSE
//   btn_left       in   1    paddle toward higher column
//   btn_right      in   1    paddle toward lower column
//   Ball_rowIndex  in   4    ball row
//   Ball_colIndex  in   4    ball column
//   Ball_direction in   2    ball direction
//   data           out  192  brick_map | paddle_mask
//   ball_run_n     out  1    registered ball engine run/reset, 1 only in PLAY
//   score          out  8    bricks cleared this game, saturating
//   bricks_left    out  8    bricks remaining
//   game_state     out  2    00 IDLE 01 PLAY 10 WIN 11 LOSE
//   lives          out  2    remaining lives (only with PLAYFIELD_LIVES_EN)
// Build option: define PLAYFIELD_LIVES_EN for a lives counter and SERVE state.
module playfield_manager
    import bricks_pkg::*;
#(
    parameter int unsigned PADDLE_W   = 4,
    parameter int unsigned BRICK_TOP  = 1,
    parameter int unsigned BRICK_ROWS = 3,
    parameter int unsigned LIVES      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic [3:0]            Ball_rowIndex,
    input  logic [3:0]            Ball_colIndex,
    input  logic [1:0]            Ball_direction,
    output logic [GRID_CELLS-1:0] data,
    output logic                  ball_run_n,
    output logic [7:0]            score,
    output logic [7:0]            bricks_left,
    output logic [1:0]            game_state
`ifdef PLAYFIELD_LIVES_EN
    ,
    output logic [1:0]            lives
`endif
);

    function automatic logic [GRID_CELLS-1:0] full_bricks();
        logic [GRID_CELLS-1:0] m;
        m = '0;
        for (int unsigned r = BRICK_TOP; r < BRICK_TOP + BRICK_ROWS; r++)
            m[r*GRID_COLS +: GRID_COLS] = '1;
        return m;
    endfunction

    localparam logic [GRID_CELLS-1:0] FULL_BRICKS = full_bricks();
    localparam logic [7:0]            BRICK_COUNT = 8'(GRID_COLS * BRICK_ROWS);
    localparam logic [3:0]            PADDLE_MAX  = 4'(GRID_COLS - PADDLE_W);
    localparam logic [3:0]            PADDLE_HOME = 4'((GRID_COLS - PADDLE_W) / 2);
    localparam logic [GRID_CELLS-1:0] PADDLE_ONES = {{(GRID_CELLS - PADDLE_W){1'b0}}, {PADDLE_W{1'b1}}};

    state_t                state;
    state_t                next_state;
    logic [GRID_CELLS-1:0] brick_map;
    logic [3:0]            paddle_col;
    logic [GRID_CELLS-1:0] paddle_mask;
    logic [GRID_CELLS-1:0] clear_mask;
    logic [1:0]            hit_raw;
    logic [1:0]            hit_count;
    logic [7:0]            bricks_after;
    logic [8:0]            score_sum;
    logic                  in_play;
    logic                  win;
    logic                  miss;
`ifdef PLAYFIELD_LIVES_EN
    logic [1:0]            lives_q;
    assign lives = lives_q;
`endif

    brick_hit_detect u_hit (
        .brick_map  (brick_map),
        .row        (Ball_rowIndex),
        .col        (Ball_colIndex),
        .dir        (Ball_direction),
        .clear_mask (clear_mask),
        .hits       (hit_raw)
    );

    assign in_play      = (state == ST_PLAY);
    assign hit_count    = in_play ? hit_raw : 2'd0;
    assign bricks_after = bricks_left - {6'b0, hit_count};
    assign score_sum    = {1'b0, score} + {7'b0, hit_count};
    assign win          = in_play && (bricks_after == 8'd0);
    assign miss         = in_play && (Ball_rowIndex == 4'(PADDLE_ROW));

    // Paddle cells start at row PADDLE_ROW, column paddle_col.
    assign paddle_mask = PADDLE_ONES << {4'(PADDLE_ROW), paddle_col};
    assign data        = brick_map | paddle_mask;
    assign game_state  = state[1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_PLAY;
            ST_PLAY: begin
                // Clearing the last brick wins even if the ball also missed.
                if (win) begin
                    next_state = ST_WIN;
                end else if (miss) begin
`ifdef PLAYFIELD_LIVES_EN
                    next_state = (lives_q > 2'd1) ? ST_SERVE : ST_LOSE;
`else
                    next_state = ST_LOSE;
`endif
                end
            end
            ST_SERVE: next_state = ST_PLAY;
            ST_WIN,
            ST_LOSE:  if (start) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            brick_map   <= FULL_BRICKS;
            paddle_col  <= PADDLE_HOME;
            score       <= '0;
            bricks_left <= BRICK_COUNT;
            ball_run_n  <= 1'b0;
`ifdef PLAYFIELD_LIVES_EN
            lives_q     <= 2'(LIVES);
`endif
        end else begin
            if (btn_left && !btn_right && (paddle_col < PADDLE_MAX))
                paddle_col <= paddle_col + 4'd1;
            else if (btn_right && !btn_left && (paddle_col != 4'd0))
                paddle_col <= paddle_col - 4'd1;

            ball_run_n <= (next_state == ST_PLAY);

            if ((state == ST_IDLE) && (next_state == ST_PLAY)) begin
                brick_map   <= FULL_BRICKS;
                score       <= '0;
                bricks_left <= BRICK_COUNT;
`ifdef PLAYFIELD_LIVES_EN
                lives_q     <= 2'(LIVES);
`endif
            end else if (in_play) begin
                brick_map   <= brick_map & ~clear_mask;
                score       <= score_sum[8] ? 8'hFF : score_sum[7:0];
                bricks_left <= bricks_after;
`ifdef PLAYFIELD_LIVES_EN
                if (next_state == ST_SERVE) lives_q <= lives_q - 2'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_playfield_manager.sv
// tb_playfield_manager: directed, table-driven bench for playfield_manager.
//   Main instance uses default parameters; a second instance with a single
//   brick row on row 10 exercises a last-brick clear coinciding with a miss.
module tb_playfield_manager;

    logic         clock;
    logic         reset;
    logic         start;
    logic         btn_left;
    logic         btn_right;
    logic [3:0]   row;
    logic [3:0]   col;
    logic [1:0]   dir;
    logic [191:0] data;
    logic         ball_run_n;
    logic [7:0]   score;
    logic [7:0]   bricks_left;
    logic [1:0]   game_state;

    logic         start2;
    logic [3:0]   row2;
    logic [3:0]   col2;
    logic [1:0]   dir2;
    logic [191:0] data2;
    logic         ball_run_n2;
    logic [7:0]   score2;
    logic [7:0]   bricks_left2;
    logic [1:0]   game_state2;

    int unsigned tests;
    int unsigned failed;

    playfield_manager dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .Ball_rowIndex  (row),
        .Ball_colIndex  (col),
        .Ball_direction (dir),
        .data           (data),
        .ball_run_n     (ball_run_n),
        .score          (score),
        .bricks_left    (bricks_left),
        .game_state     (game_state)
    );

    playfield_manager #(
        .PADDLE_W   (4),
        .BRICK_TOP  (10),
        .BRICK_ROWS (1),
        .LIVES      (3)
    ) dut2 (
        .clock          (clock),
        .reset          (reset),
        .start          (start2),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .Ball_rowIndex  (row2),
        .Ball_colIndex  (col2),
        .Ball_direction (dir2),
        .data           (data2),
        .ball_run_n     (ball_run_n2),
        .score          (score2),
        .bricks_left    (bricks_left2),
        .game_state     (game_state2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        bl;
        logic        br;
        logic [3:0]  r;
        logic [3:0]  c;
        logic [1:0]  d;
        logic [7:0]  exp_score;
        logic [7:0]  exp_left;
        int unsigned bit_idx;
        logic        bit_val;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ball_idle();
        row = 4'd8; col = 4'd7; dir = 2'b00;
    endtask

    logic [191:0] reset_map;

    initial begin
        tests  = 0;
        failed = 0;

        // Ball (r,c,dir) -> expected score, bricks_left, one data bit.
        vecs[0]  = '{1'b0, 1'b0, 4'd4,  4'd5,  2'b00, 8'd1, 8'd47, 53,  1'b0}; // V only
        vecs[1]  = '{1'b0, 1'b0, 4'd4,  4'd5,  2'b00, 8'd2, 8'd46, 52,  1'b0}; // diagonal
        vecs[2]  = '{1'b0, 1'b0, 4'd3,  4'd8,  2'b00, 8'd4, 8'd44, 40,  1'b0}; // V and H
        vecs[3]  = '{1'b0, 1'b0, 4'd8,  4'd7,  2'b00, 8'd4, 8'd44, 55,  1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'd8,  4'd7,  2'b00, 8'd4, 8'd44, 39,  1'b1}; // D kept
        vecs[5]  = '{1'b0, 1'b0, 4'd2,  4'd0,  2'b00, 8'd5, 8'd43, 16,  1'b0}; // col 0 edge
        vecs[6]  = '{1'b0, 1'b0, 4'd8,  4'd7,  2'b00, 8'd5, 8'd43, 47,  1'b1}; // no wrap
        vecs[7]  = '{1'b0, 1'b0, 4'd2,  4'd15, 2'b11, 8'd6, 8'd42, 63,  1'b0}; // col 15 edge
        vecs[8]  = '{1'b0, 1'b0, 4'd8,  4'd7,  2'b00, 8'd6, 8'd42, 32,  1'b1}; // no wrap
        vecs[9]  = '{1'b0, 1'b0, 4'd0,  4'd3,  2'b11, 8'd7, 8'd41, 19,  1'b0}; // from row 0
        vecs[10] = '{1'b1, 1'b1, 4'd8,  4'd7,  2'b00, 8'd7, 8'd41, 185, 1'b1}; // both: hold
        vecs[11] = '{1'b0, 1'b1, 4'd8,  4'd7,  2'b00, 8'd7, 8'd41, 185, 1'b0}; // right: 6->5
        vecs[12] = '{1'b1, 1'b0, 4'd8,  4'd7,  2'b00, 8'd7, 8'd41, 181, 1'b0}; // left: 5->6
        vecs[13] = '{1'b0, 1'b0, 4'd10, 4'd6,  2'b10, 8'd7, 8'd41, 182, 1'b1}; // paddle kept

        reset_map = '0;
        for (int r = 1; r <= 3; r++)
            for (int c = 0; c < 16; c++)
                reset_map[r*16 + c] = 1'b1;
        for (int c = 6; c < 10; c++)
            reset_map[176 + c] = 1'b1;

        reset = 1'b0; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        ball_idle();
        start2 = 1'b0; row2 = 4'd8; col2 = 4'd7; dir2 = 2'b00;

        #12;
        chk("reset_state",  192'(game_state), 192'(2'b00));
        chk("reset_run_n",  192'(ball_run_n), 192'(1'b0));
        chk("reset_score",  192'(score), 192'(8'd0));
        chk("reset_left",   192'(bricks_left), 192'(8'd48));
        chk("reset_data",   data, reset_map);
        reset = 1'b1;

        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_state",  192'(game_state), 192'(2'b01));
        chk("start_run_n",  192'(ball_run_n), 192'(1'b1));
        chk("start_left",   192'(bricks_left), 192'(8'd48));
        chk("start_paddle", 192'(data[187:182]), 192'(6'b001111));

        for (int i = 0; i < 14; i++) begin
            btn_left = vecs[i].bl; btn_right = vecs[i].br;
            row = vecs[i].r; col = vecs[i].c; dir = vecs[i].d;
            step();
            chk($sformatf("vec%0d_score", i), 192'(score), 192'(vecs[i].exp_score));
            chk($sformatf("vec%0d_left", i),  192'(bricks_left), 192'(vecs[i].exp_left));
            chk($sformatf("vec%0d_state", i), 192'(game_state), 192'(2'b01));
            chk($sformatf("vec%0d_bit", i),   192'(data[vecs[i].bit_idx]), 192'(vecs[i].bit_val));
        end
        btn_left = 1'b0; btn_right = 1'b0;
        ball_idle();

        start = 1'b1;
        step();
        start = 1'b0;
        chk("play_ignores_start", 192'(game_state), 192'(2'b01));

        btn_left = 1'b1;
        for (int i = 0; i < 12; i++) step();
        btn_left = 1'b0;
        chk("paddle_limit", 192'(data[191:176]), 192'(16'hF000));

        row = 4'd11; col = 4'd7; dir = 2'b00;
        step();
        ball_idle();
        chk("miss_state", 192'(game_state), 192'(2'b11));
        chk("miss_run_n", 192'(ball_run_n), 192'(1'b0));
        chk("miss_score", 192'(score), 192'(8'd7));
        step();
        chk("lose_hold", 192'(game_state), 192'(2'b11));

        start = 1'b1;
        step();
        start = 1'b0;
        chk("lose_to_idle", 192'(game_state), 192'(2'b00));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_state", 192'(game_state), 192'(2'b01));
        chk("restart_run_n", 192'(ball_run_n), 192'(1'b1));
        chk("restart_score", 192'(score), 192'(8'd0));
        chk("restart_left",  192'(bricks_left), 192'(8'd48));
        chk("restart_bricks", 192'(data[63:16]), 192'({48{1'b1}}));

        // Single-row instance: clear 15 bricks, then the 16th while on row 11.
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("w_start_left", 192'(bricks_left2), 192'(8'd16));
        for (int c = 0; c < 15; c++) begin
            row2 = 4'd9; col2 = 4'(c); dir2 = 2'b11;
            step();
        end
        row2 = 4'd8; col2 = 4'd7; dir2 = 2'b00;
        chk("w_left_one",  192'(bricks_left2), 192'(8'd1));
        chk("w_score_15",  192'(score2), 192'(8'd15));
        chk("w_still_play", 192'(game_state2), 192'(2'b01));
        row2 = 4'd11; col2 = 4'd15; dir2 = 2'b00;
        step();
        row2 = 4'd8; col2 = 4'd7; dir2 = 2'b00;
        chk("win_priority", 192'(game_state2), 192'(2'b10));
        chk("win_left",     192'(bricks_left2), 192'(8'd0));
        chk("win_score",    192'(score2), 192'(8'd16));
        chk("win_run_n",    192'(ball_run_n2), 192'(1'b0));
        chk("win_last_bit", 192'(data2[175]), 192'(1'b0));

        // Mid-game asynchronous reset, away from any clock edge.
        row = 4'd4; col = 4'd5; dir = 2'b00;
        step();
        ball_idle();
        chk("pre_reset_score", 192'(score), 192'(8'd1));
        #2 reset = 1'b0;
        #1;
        chk("async_state", 192'(game_state), 192'(2'b00));
        chk("async_score", 192'(score), 192'(8'd0));
        chk("async_left",  192'(bricks_left), 192'(8'd48));
        chk("async_run_n", 192'(ball_run_n), 192'(1'b0));
        chk("async_data",  data, reset_map);
        #2 reset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
